alu_seq: RTL and testbench

Parametrised, handshaked successor to the team's 8-bit combinational ALU: WIDTH-bit operands, 3-bit opcode, registered result with status flags (zero, carry, overflow), and a multi-cycle shift-add unsigned multiply. It sits between an operand-issuing controller and a result consumer. Both sides use valid/ready handshakes, so the consumer may stall results indefinitely. One operation is in flight at a time.

---
 rtl/alu_seq.sv | 184 ++++++++++++++++++
 tb/tb_alu_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: handshaked WIDTH-bit ALU with registered result and flags, and an
// unsigned shift-add multiplier that takes WIDTH cycles.
// Only one operation is in flight at a time.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   in_valid/in_ready   operation handshake (opcode, a, b captured at accept)
//   out_valid/out_ready result handshake (y, zero, carry, ovf)
//
// Operations: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MUL (unsigned).
// Latency from the accept edge to out_valid: 1 edge for ops 0-6, WIDTH+1
// edges for MUL.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             carry,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_HOLD} state_t;

  state_t               state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic [WIDTH-1:0]     opa_q, opa_d, opb_q, opb_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d, acc_q, acc_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     y_q, y_d;
  logic                 zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d;

  logic [WIDTH:0]       sum, dif;
  logic [WIDTH-1:0]     res;
  logic                 res_c, res_v;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid) state_d = (opcode == 3'd7) ? S_MUL : S_EXEC;
      S_EXEC: state_d = S_HOLD;
      S_MUL:  if (cnt_q == '0) state_d = S_HOLD;
      S_HOLD: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decode from state only
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_HOLD);
  end

  // ALU result from the captured operands
  always_comb begin
    sum   = {1'b0, opa_q} + {1'b0, opb_q};
    dif   = {1'b0, opa_q} - {1'b0, opb_q};
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (op_q)
      3'd0: begin
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) && (sum[WIDTH-1] != opa_q[WIDTH-1]);
      end
      3'd1: begin
        res   = dif[WIDTH-1:0];
        res_c = dif[WIDTH];  // borrow out of the zero-extended subtract
        res_v = (opa_q[WIDTH-1] != opb_q[WIDTH-1]) && (dif[WIDTH-1] != opa_q[WIDTH-1]);
      end
      3'd2: res = opa_q & opb_q;
      3'd3: res = opa_q | opb_q;
      3'd4: res = opa_q ^ opb_q;
      3'd5: begin
        res   = {opa_q[WIDTH-2:0], 1'b0};
        res_c = opa_q[WIDTH-1];
      end
      3'd6: begin
        res   = {1'b0, opa_q[WIDTH-1:1]};
        res_c = opa_q[0];
      end
      default: ;
    endcase
  end

  // Datapath next-state
  always_comb begin
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    y_d      = y_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: if (in_valid) begin
        op_d     = opcode;
        opa_d    = a;
        opb_d    = b;
        mcand_d  = {{WIDTH{1'b0}}, a};
        mplier_d = b;
        acc_d    = '0;
        cnt_d    = (opcode == 3'd7) ? CW'(WIDTH) : '0;
      end
      S_EXEC: begin
        y_d     = res;
        zero_d  = (res == '0);
        carry_d = res_c;
        ovf_d   = res_v;
      end
      S_MUL: begin
        if (cnt_q != '0) begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q - CW'(1);
        end else begin
          // All WIDTH partial products accumulated: publish the low half
          y_d     = acc_q[WIDTH-1:0];
          zero_d  = (acc_q[WIDTH-1:0] == '0);
          carry_d = 1'b0;
          ovf_d   = (acc_q[2*WIDTH-1:WIDTH] != '0);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      y_q      <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      y_q      <= y_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
    end
  end

  assign y     = y_q;
  assign zero  = zero_q;
  assign carry = carry_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed and randomized checks of alu_seq at WIDTH=8: reset, flags,
// latency, multiply, backpressure, and reset during a multiply.
module tb_alu_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   opcode = '0;
  logic [W-1:0] a = '0, b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] y;
  logic         zero, carry, ovf;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .zero(zero), .carry(carry), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: returns {ovf, carry, zero, y}
  function automatic logic [10:0] model(input logic [2:0] op, input logic [7:0] xa, input logic [7:0] xb);
    int ua, ub, sa, sb, r, s;
    logic [7:0] ry;
    logic rc, rv;
    ua = int'(xa); ub = int'(xb);
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    rc = 1'b0; rv = 1'b0;
    case (op)
      3'd0: begin r = ua + ub; s = sa + sb; rc = (r > 255); rv = (s > 127) || (s < -128); end
      3'd1: begin r = ua - ub + 256; s = sa - sb; rc = (ua < ub); rv = (s > 127) || (s < -128); end
      3'd2: r = int'(xa & xb);
      3'd3: r = int'(xa | xb);
      3'd4: r = int'(xa ^ xb);
      3'd5: begin r = ua * 2; rc = xa[7]; end
      3'd6: begin r = ua / 2; rc = xa[0]; end
      default: begin r = ua * ub; rv = (r > 255); end
    endcase
    ry = 8'(r % 256);
    return {rv, rc, (ry == 8'h00), ry};
  endfunction

  logic [W-1:0] ry;
  logic         rz, rc, rv;
  int           rlat;

  // Present one operation and return just after its accept edge.
  task automatic issue(input logic [2:0] op, input logic [7:0] xa, input logic [7:0] xb);
    int n = 0;
    while (!in_ready && n < 40) begin @(posedge clk); #1; n++; end
    chk("in_ready before issue", 32'(in_ready), 32'd1);
    in_valid = 1'b1; opcode = op; a = xa; b = xb;
    @(posedge clk); #1;
    in_valid = 1'b0; opcode = ~op; a = ~xa; b = ~xb;  // captured values must not follow
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("out_valid timeout", 32'(out_valid), 32'd1);
    ry = y; rz = zero; rc = carry; rv = ovf;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_exp(input string tag, input logic [2:0] op, input logic [7:0] xa, input logic [7:0] xb,
                         input logic [7:0] ey, input logic ez, input logic ec, input logic ev, input int elat);
    issue(op, xa, xb);
    wait_out(rlat);
    chk({tag, " y"}, 32'(ry), 32'(ey));
    chk({tag, " zero"}, 32'(rz), 32'(ez));
    chk({tag, " carry"}, 32'(rc), 32'(ec));
    chk({tag, " ovf"}, 32'(rv), 32'(ev));
    chk({tag, " latency"}, 32'(rlat), 32'(elat));
    consume();
  endtask

  initial begin
    logic [7:0]  xa, xb;
    logic [10:0] m;
    int          seen;

    // Reset state
    #2;
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst y", 32'(y), 32'd0);
    chk("rst flags", 32'({zero, carry, ovf}), 32'd0);
    @(posedge clk); #1; rst = 1'b0;

    // Flags
    run_exp("add 7f+01", 3'd0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1);
    run_exp("add ff+01", 3'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1);
    run_exp("sub 00-01", 3'd1, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b1, 1'b0, 1);
    run_exp("sub 80-01", 3'd1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1, 1);
    run_exp("and",       3'd2, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1);
    run_exp("or",        3'd3, 8'hA0, 8'h05, 8'hA5, 1'b0, 1'b0, 1'b0, 1);
    run_exp("xor",       3'd4, 8'h5A, 8'h5A, 8'h00, 1'b1, 1'b0, 1'b0, 1);
    run_exp("shl 81",    3'd5, 8'h81, 8'hFF, 8'h02, 1'b0, 1'b1, 1'b0, 1);
    run_exp("shr 01",    3'd6, 8'h01, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b0, 1);

    // Multiply
    run_exp("mul 0f*11", 3'd7, 8'h0F, 8'h11, 8'hFF, 1'b0, 1'b0, 1'b0, 9);
    run_exp("mul 10*10", 3'd7, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0, 1'b1, 9);

    // Randomized sweep against the model
    for (int op = 0; op < 8; op++) begin
      for (int i = 0; i < 6; i++) begin
        xa = 8'($urandom_range(0, 255));
        xb = 8'($urandom_range(0, 255));
        m  = model(3'(op), xa, xb);
        run_exp($sformatf("sweep op%0d %02h,%02h", op, xa, xb), 3'(op), xa, xb,
                m[7:0], m[8], m[9], m[10], (op == 7) ? 9 : 1);
      end
    end

    // Backpressure: hold result for 10 cycles, ignore a stray in_valid
    issue(3'd0, 8'h10, 8'h20);
    wait_out(rlat);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin in_valid = 1'b1; opcode = 3'd7; a = 8'h55; b = 8'h66; end
      else in_valid = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("bp y c%0d", i), 32'(y), 32'h30);
      chk($sformatf("bp in_ready c%0d", i), 32'(in_ready), 32'd0);
      chk($sformatf("bp out_valid c%0d", i), 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp release out_valid", 32'(out_valid), 32'd0);
    chk("bp release in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; opcode = 3'd0; a = 8'h01; b = 8'h01;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp next accepted", 32'(in_ready), 32'd0);
    wait_out(rlat);
    chk("bp next y", 32'(ry), 32'h02);
    chk("bp next latency", 32'(rlat), 32'd1);
    consume();

    // out_ready held high in advance: result lasts exactly one cycle
    out_ready = 1'b1;
    issue(3'd4, 8'h0F, 8'hF0);
    wait_out(rlat);
    chk("early ready y", 32'(ry), 32'hFF);
    @(posedge clk); #1;
    chk("early ready one cycle", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Leave a nonzero result with ovf set, then reset in the middle of a MUL
    run_exp("mul ff*ff", 3'd7, 8'hFF, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, 9);
    issue(3'd7, 8'h03, 8'h05);
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midmul rst in_ready", 32'(in_ready), 32'd1);
    chk("midmul rst out_valid", 32'(out_valid), 32'd0);
    chk("midmul rst y", 32'(y), 32'd0);
    chk("midmul rst flags", 32'({zero, carry, ovf}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("midmul no out_valid", 32'(seen), 32'd0);
    run_exp("post rst add", 3'd0, 8'h02, 8'h03, 8'h05, 1'b0, 1'b0, 1'b0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
